// File: rtl/midi_tx_pkg.sv
// Shared MIDI constants, status-byte classification and message-length decode.
package midi_tx_pkg;

  localparam int unsigned MidiBaud = 31_250;

  typedef enum logic [1:0] {
    ClsChannel,
    ClsSysCommon,
    ClsRealtime,
    ClsInvalid
  } status_cls_e;

  function automatic status_cls_e status_cls(input logic [7:0] status);
    if (!status[7]) begin
      return ClsInvalid;
    end else if (status[7:4] != 4'hF) begin
      return ClsChannel;
    end else if (!status[3]) begin
      return ClsSysCommon;
    end else begin
      return ClsRealtime;
    end
  endfunction

  // Total bytes on the wire for a message, status byte included.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2'd3;
      4'hC, 4'hD:                   return 2'd2;
      4'hF: begin
        case (status[3:0])
          4'h2:       return 2'd3;
          4'h1, 4'h3: return 2'd2;
          default:    return 2'd1;
        endcase
      end
      default: return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/midi_tx_if.sv
// Message handshake channel into the MIDI transmitter.
interface midi_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_status;
  logic [6:0] in_data1;
  logic [6:0] in_data2;

  modport master (output in_valid, in_status, in_data1, in_data2, input in_ready);
  modport slave  (input in_valid, in_status, in_data1, in_data2, output in_ready);
endinterface

// File: rtl/midi_tx_uart_tx_byte.sv
// One 8N1 frame per start pulse; a start during the final stop cycle chains frames with no gap.
module midi_tx_uart_tx_byte #(
  parameter int unsigned Div = 3200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_done,
  output logic       o_tx
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == CntLast);
  assign o_done    = (r_state == StStop) && w_bit_end;

  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      StStart: o_tx = 1'b0;
      StData:  o_tx = r_shift[0];
      default: o_tx = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (i_start) begin
          w_state_nxt = StStart;
          w_shift_nxt = i_byte;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_nxt = StData;
          w_bit_nxt   = 3'd0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b1, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = StStop;
          end
        end
      end
      StStop: begin
        if (w_bit_end) begin
          if (i_start) begin
            w_state_nxt = StStart;
            w_shift_nxt = i_byte;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT message transmitter: length decode, running status and per-byte sequencing.
// The first byte starts on the accepting edge; later bytes load in the previous stop bit's last cycle.
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned BAUD           = MidiBaud,
  parameter bit          RUNNING_STATUS = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  midi_tx_if.slave i_msg,
  output logic o_tx,
  output logic o_busy,
  output logic o_err
);

  localparam int unsigned Div = CLK_HZ / BAUD;

  typedef enum logic [1:0] {StIdle, StSend, StErr} state_e;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_status, r_run, w_run_nxt;
  logic [6:0]  r_data1, r_data2;
  logic [1:0]  r_idx, w_idx_nxt, r_last;
  logic [1:0]  w_len, w_first;
  logic [7:0]  w_byte, w_sel;
  logic        w_accept, w_skip, w_start, w_done;
  status_cls_e w_cls;

  assign w_accept = i_msg.in_valid && (r_state == StIdle);
  assign w_cls    = status_cls(i_msg.in_status);
  assign w_len    = msg_len(i_msg.in_status);
  // r_run == 0 means no stored status; a channel status can never equal it.
  assign w_skip   = RUNNING_STATUS && (w_cls == ClsChannel) && (i_msg.in_status == r_run);
  assign w_first  = w_skip ? 2'd1 : 2'd0;
  assign w_sel    = (r_idx == 2'd0) ? r_status :
                    (r_idx == 2'd1) ? {1'b0, r_data1} : {1'b0, r_data2};

  assign i_msg.in_ready = (r_state == StIdle);
  assign o_busy         = (r_state == StSend);
  assign o_err          = (r_state == StErr);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_byte      = 8'hFF;
    w_idx_nxt   = r_idx;
    w_run_nxt   = r_run;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_cls == ClsInvalid) begin
            w_state_nxt = StErr;
          end else begin
            w_state_nxt = StSend;
            w_start     = 1'b1;
            w_byte      = w_skip ? {1'b0, i_msg.in_data1} : i_msg.in_status;
            w_idx_nxt   = w_first + 2'd1;
            if (RUNNING_STATUS) begin
              case (w_cls)
                ClsChannel:   w_run_nxt = i_msg.in_status;
                ClsSysCommon: w_run_nxt = '0;
                default:      w_run_nxt = r_run;
              endcase
            end
          end
        end
      end
      StSend: begin
        if (w_done) begin
          if (r_idx <= r_last) begin
            w_start   = 1'b1;
            w_byte    = w_sel;
            w_idx_nxt = r_idx + 2'd1;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      StErr:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_run    <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_status <= '0;
      r_data1  <= '0;
      r_data2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_status <= i_msg.in_status;
        r_data1  <= i_msg.in_data1;
        r_data2  <= i_msg.in_data2;
        r_last   <= w_len - 2'd1;
      end
    end
  end

  midi_tx_uart_tx_byte #(
    .Div(Div)
  ) u_byte (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(w_start),
    .i_byte (w_byte),
    .o_done (w_done),
    .o_tx   (o_tx)
  );

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: decodes the serial line and checks bytes, timing and handshake.
module tb_midi_tx;

  localparam int unsigned Baud  = 31_250;
  localparam int unsigned Div   = 16;
  localparam int unsigned ClkHz = Baud * Div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy, err;

  midi_tx_if bus();

  midi_tx #(
    .CLK_HZ        (ClkHz),
    .BAUD          (Baud),
    .RUNNING_STATUS(1'b1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_msg  (bus),
    .o_tx   (tx),
    .o_busy (busy),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit on the falling clock edge.
  bit          mon_act  = 1'b0;
  int unsigned mon_cnt  = 0;
  int unsigned mon_ferr = 0;
  logic [7:0]  mon_byte = 8'h00;
  logic [7:0]  q_bytes[$];
  int unsigned q_start[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act <= 1'b1;
        mon_cnt <= 1;
        q_start.push_back(cyc);
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if ((mon_cnt % Div) == (Div / 2) && (mon_cnt / Div) >= 1) begin
        if ((mon_cnt / Div) == 9) begin
          if (tx !== 1'b1) mon_ferr <= mon_ferr + 1;
          q_bytes.push_back(mon_byte);
          mon_act <= 1'b0;
        end else begin
          mon_byte <= {tx, mon_byte[7:1]};
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
    int unsigned w = 0;
    while (bus.in_ready !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 4000) check_eq("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_status = st;
    bus.in_data1  = d1;
    bus.in_data2  = d2;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic run_msg(input string tag, input logic [7:0] st, input logic [6:0] d1,
                         input logic [6:0] d2, input int unsigned n_exp,
                         input logic [23:0] exp_bytes);
    int unsigned bcyc = 0;
    int unsigned nrdy = 0;
    int unsigned w    = 0;
    logic first_tx, first_busy;
    q_bytes.delete();
    q_start.delete();
    mon_ferr = 0;
    send(st, d1, d2);
    @(negedge clk);
    first_tx   = tx;
    first_busy = busy;
    while (bus.in_ready !== 1'b1 && w < 4000) begin
      if (busy === 1'b1) bcyc++;
      nrdy++;
      w++;
      @(negedge clk);
    end
    check_eq({tag, "_timeout"}, w < 4000, 32'd1);
    check_eq({tag, "_first_tx"}, {31'd0, first_tx}, 32'd0);
    check_eq({tag, "_first_busy"}, {31'd0, first_busy}, 32'd1);
    check_eq({tag, "_busy_cycles"}, bcyc, n_exp * 10 * Div);
    check_eq({tag, "_notready_cycles"}, nrdy, n_exp * 10 * Div);
    check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_nbytes"}, q_bytes.size(), n_exp);
    check_eq({tag, "_framing"}, mon_ferr, 32'd0);
    for (int i = 0; i < int'(n_exp); i++) begin
      if (i < q_bytes.size())
        check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, q_bytes[i]},
                 {24'd0, exp_bytes[23 - 8 * i -: 8]});
    end
    if (q_start.size() > 0) check_eq({tag, "_start_lat"}, q_start[0], acc_cyc);
    for (int i = 1; i < q_start.size(); i++)
      check_eq($sformatf("%s_gap%0d", tag, i), q_start[i] - q_start[i-1], 10 * Div);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_status = 8'h00;
    bus.in_data1  = 7'h00;
    bus.in_data2  = 7'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_msg("t1_note_on", 8'h90, 7'h3C, 7'h64, 3, 24'h903C64);
    run_msg("t2_running", 8'h90, 7'h3E, 7'h40, 2, 24'h3E4000);
    run_msg("t3_prog", 8'hC5, 7'h07, 7'h00, 2, 24'hC50700);
    run_msg("t3_clock", 8'hF8, 7'h00, 7'h00, 1, 24'hF80000);
    run_msg("t3_prog_rs", 8'hC5, 7'h08, 7'h00, 1, 24'h080000);
    run_msg("t4_note", 8'h90, 7'h3C, 7'h00, 3, 24'h903C00);
    run_msg("t4_tune", 8'hF6, 7'h00, 7'h00, 1, 24'hF60000);
    run_msg("t4_note_clr", 8'h90, 7'h3C, 7'h00, 3, 24'h903C00);

    q_start.delete();
    send(8'h3C, 7'h00, 7'h00);
    @(negedge clk);
    check_eq("t5_err_hi", {31'd0, err}, 32'd1);
    check_eq("t5_ready_lo", {31'd0, bus.in_ready}, 32'd0);
    check_eq("t5_tx_a", {31'd0, tx}, 32'd1);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("t5_err_lo", {31'd0, err}, 32'd0);
    check_eq("t5_ready_hi", {31'd0, bus.in_ready}, 32'd1);
    check_eq("t5_tx_b", {31'd0, tx}, 32'd1);
    check_eq("t5_no_frames", q_start.size(), 32'd0);

    send(8'h90, 7'h3C, 7'h64);
    repeat (25) @(posedge clk);
    #1;
    check_eq("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * Div) @(negedge clk);
    check_eq("t6_idle_tx", {31'd0, tx}, 32'd1);
    run_msg("t6_resend", 8'h90, 7'h3C, 7'h64, 3, 24'h903C64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
